// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: runs a host-programmed list of PE configurations. Each entry is
//   applied for a RUN_LEN-cycle bitstream window, and y_outmem is summed over that window.
// Latency: start at T -> first result at T+RUN_LEN+2, then one result every RUN_LEN+2 cycles.
// Backpressure: none; the result is a one-cycle strobe, and start is ignored while busy.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr_en/wr_addr/wr_cfg/wr_xmem   program write port (accepted only when idle)
//   n_last, start, abort           sequence control
//   y_outmem                       PE memory-side output
//   config_sig, x_mem, pe_en       PE drive
//   busy, done                     sequence status
//   res_valid/res_idx/res_acc/res_last   per-entry result
module pe_seq_ctrl #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int RUN_LEN = 256,
  parameter int CNT_W   = 8,
  parameter int ACC_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [29:0]      wr_cfg,
  input  logic [7:0]       wr_xmem,
  input  logic [AW-1:0]    n_last,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       y_outmem,
  output logic [29:0]      config_sig,
  output logic [7:0]       x_mem,
  output logic             pe_en,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [AW-1:0]    res_idx,
  output logic [ACC_W-1:0] res_acc,
  output logic [7:0]       res_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_STORE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [37:0]      mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    n_last_q;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);
  // Sum including the current sample, so the final window cycle is counted.
  assign acc_sum  = acc + {{(ACC_W-8){1'b0}}, y_outmem};

  // Program memory is not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && state == S_IDLE) begin
      mem[wr_addr] <= {wr_cfg, wr_xmem};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_RUN;
      S_RUN:   if (cnt_last) state_nxt = S_STORE;
      S_STORE: state_nxt = (idx == n_last_q) ? S_DONE : S_LOAD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) begin
      state_nxt = S_IDLE;
    end
  end

  // Status strobes decode straight from the state, so an abort clears them
  // in the very next cycle while a coincident STORE still shows its strobe.
  assign pe_en     = (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign res_valid = (state == S_STORE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      n_last_q   <= '0;
      cnt        <= '0;
      acc        <= '0;
      config_sig <= '0;
      x_mem      <= '0;
      res_idx    <= '0;
      res_acc    <= '0;
      res_last   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx      <= '0;
            n_last_q <= n_last;
          end
        end
        S_LOAD: begin
          {config_sig, x_mem} <= mem[idx];
          cnt <= '0;
          acc <= '0;
        end
        S_RUN: begin
          acc <= acc_sum;
          cnt <= cnt + CNT_W'(1);
          // An aborted window never reaches STORE, so it must not disturb
          // the previously published result.
          if (cnt_last && !abort) begin
            res_acc  <= acc_sum;
            res_last <= y_outmem;
            res_idx  <= idx;
          end
        end
        S_STORE: begin
          if (state_nxt == S_LOAD) begin
            idx <= idx + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb_pe_seq_ctrl: scoreboard bench for pe_seq_ctrl; one short-window instance
//   (RUN_LEN=4) and one full-scale instance (RUN_LEN=256) share the host inputs.
// Expected results are queued when a sequence is launched and matched in order.
module tb_pe_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [29:0] wr_cfg;
  logic [7:0]  wr_xmem;
  logic [2:0]  n_last;
  logic        start4, start256;
  logic        abort;
  logic        abort256;
  logic [7:0]  y_outmem;

  logic [29:0] cfg4, cfg_f;
  logic [7:0]  xm4, xm_f;
  logic        pe4, pe_f, busy4, busy_f, done4, done_f, rv4, rv_f;
  logic [2:0]  ri4, ri_f;
  logic [15:0] ra4, ra_f;
  logic [7:0]  rl4, rl_f;

  always #5 clk = ~clk;

  pe_seq_ctrl #(.RUN_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cfg(wr_cfg),
    .wr_xmem(wr_xmem), .n_last(n_last), .start(start4), .abort(abort),
    .y_outmem(y_outmem), .config_sig(cfg4), .x_mem(xm4), .pe_en(pe4),
    .busy(busy4), .done(done4), .res_valid(rv4), .res_idx(ri4),
    .res_acc(ra4), .res_last(rl4)
  );

  pe_seq_ctrl #(.RUN_LEN(256)) dut256 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_cfg(wr_cfg),
    .wr_xmem(wr_xmem), .n_last(n_last), .start(start256), .abort(abort256),
    .y_outmem(y_outmem), .config_sig(cfg_f), .x_mem(xm_f), .pe_en(pe_f),
    .busy(busy_f), .done(done_f), .res_valid(rv_f), .res_idx(ri_f),
    .res_acc(ra_f), .res_last(rl_f)
  );

  typedef struct {
    int          idx;
    int          acc;
    int          last;
    int          k;
    logic [29:0] cfg;
    logic [7:0]  xm;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int   done_k;
  int   pe_cnt;
  int   last_busy_k;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic write_entry(input logic [2:0] a, input logic [29:0] c, input logic [7:0] x);
    wr_en = 1'b1; wr_addr = a; wr_cfg = c; wr_xmem = x;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input int idx, input int acc, input int last, input int k,
                          input logic [29:0] c, input logic [7:0] x);
    res_t e;
    e.idx = idx; e.acc = acc; e.last = last; e.k = k; e.cfg = c; e.xm = x;
    exp_q.push_back(e);
  endtask

  // Runs ncyc cycles after a start was driven (cycle k=1 is the LOAD cycle),
  // recording every result strobe, the done cycle and pe_en/busy activity.
  task automatic observe(input int ncyc, input bit big, input int abort_k,
                         input int wr_k, input logic [29:0] wr_c);
    res_t g;
    got_q.delete();
    done_k = -1; pe_cnt = 0; last_busy_k = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (big ? rv_f : rv4) begin
        g.idx  = int'(big ? ri_f : ri4);
        g.acc  = int'(big ? ra_f : ra4);
        g.last = int'(big ? rl_f : rl4);
        g.k    = k;
        g.cfg  = big ? cfg_f : cfg4;
        g.xm   = big ? xm_f : xm4;
        got_q.push_back(g);
      end
      if ((big ? done_f : done4) && done_k < 0) done_k = k;
      if (big ? pe_f : pe4) pe_cnt++;
      if (big ? busy_f : busy4) last_busy_k = k;
      start4 = 1'b0; start256 = 1'b0;
      abort = (k == abort_k);
      wr_en = (k == wr_k);
      if (k == wr_k) begin
        wr_addr = 3'd0; wr_cfg = wr_c;
      end
    end
    abort = 1'b0; wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({cfg4, xm4, pe4, busy4, done4, rv4, ri4, ra4, rl4} !== '0)
      $display("FAIL reset_por4 got=%h required=0", {cfg4, xm4, pe4, busy4, done4, rv4, ri4, ra4, rl4});
    else n_pass++;
    n_checks++;
    if ({cfg_f, xm_f, pe_f, busy_f, done_f, rv_f, ri_f, ra_f, rl_f} !== '0)
      $display("FAIL reset_por256 got=%h required=0", {cfg_f, xm_f, pe_f, busy_f, done_f, rv_f, ri_f, ra_f, rl_f});
    else n_pass++;
    // Reset in the middle of a window.
    write_entry(3'd0, 30'h2AAAAAAA, 8'h55);
    y_outmem = 8'h11; n_last = 3'd0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pe4 !== 1'b1) $display("FAIL reset_prerun pe_en got=%b required=1", pe4);
    else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({cfg4, xm4, pe4, busy4, done4, rv4, ri4, ra4, rl4} !== '0)
      $display("FAIL reset_midrun got=%h required=0", {cfg4, xm4, pe4, busy4, done4, rv4, ri4, ra4, rl4});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy4, pe4} !== 2'b00) $display("FAIL reset_idle busy/pe got=%b required=00", {busy4, pe4});
    else n_pass++;
  endtask

  task automatic test_single();
    res_t e, g;
    write_entry(3'd0, 30'h0FCFCF1, 8'h3F);
    y_outmem = 8'h3F; n_last = 3'd0;
    push_exp(0, 252, 8'h3F, 6, 30'h0FCFCF1, 8'h3F);
    start4 = 1'b1;
    observe(10, 1'b0, -1, -1, 30'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL single_result missing idx=%0d", e.idx);
      else begin
        g = got_q.pop_front();
        if (g.idx !== e.idx || g.acc !== e.acc || g.last !== e.last || g.k !== e.k || g.cfg !== e.cfg || g.xm !== e.xm)
          $display("FAIL single_result got idx=%0d acc=%0d last=%0h k=%0d cfg=%h xm=%h required idx=%0d acc=%0d last=%0h k=%0d cfg=%h xm=%h",
                   g.idx, g.acc, g.last, g.k, g.cfg, g.xm, e.idx, e.acc, e.last, e.k, e.cfg, e.xm);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0) $display("FAIL single_extra got=%0d required=0", got_q.size()); else n_pass++;
    n_checks++;
    if (done_k != 7) $display("FAIL single_done got=%0d required=7", done_k); else n_pass++;
    n_checks++;
    if (pe_cnt != 4) $display("FAIL single_pe_en got=%0d required=4", pe_cnt); else n_pass++;
    n_checks++;
    if (last_busy_k != 7) $display("FAIL single_busy got=%0d required=7", last_busy_k); else n_pass++;
  endtask

  task automatic test_multi();
    res_t e, g;
    for (int i = 0; i < 3; i++) write_entry(3'(i), 30'h100 + 30'(i), 8'h10 + 8'(i));
    y_outmem = 8'h3C; n_last = 3'd2;
    for (int i = 0; i < 3; i++) push_exp(i, 240, 8'h3C, 6 + 6 * i, 30'h100 + 30'(i), 8'h10 + 8'(i));
    start4 = 1'b1;
    observe(22, 1'b0, -1, -1, 30'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL multi_result missing idx=%0d", e.idx);
      else begin
        g = got_q.pop_front();
        if (g.idx !== e.idx || g.acc !== e.acc || g.last !== e.last || g.k !== e.k || g.cfg !== e.cfg || g.xm !== e.xm)
          $display("FAIL multi_result got idx=%0d acc=%0d last=%0h k=%0d cfg=%h xm=%h required idx=%0d acc=%0d last=%0h k=%0d cfg=%h xm=%h",
                   g.idx, g.acc, g.last, g.k, g.cfg, g.xm, e.idx, e.acc, e.last, e.k, e.cfg, e.xm);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0) $display("FAIL multi_extra got=%0d required=0", got_q.size()); else n_pass++;
    n_checks++;
    if (done_k != 19) $display("FAIL multi_done got=%0d required=19", done_k); else n_pass++;
    n_checks++;
    if (pe_cnt != 12) $display("FAIL multi_pe_en got=%0d required=12", pe_cnt); else n_pass++;
  endtask

  task automatic test_full_scale();
    res_t e, g;
    write_entry(3'd0, 30'h3FFFFFFF, 8'hFF);
    y_outmem = 8'hFF; n_last = 3'd0;
    push_exp(0, 65280, 8'hFF, 258, 30'h3FFFFFFF, 8'hFF);
    start256 = 1'b1;
    observe(262, 1'b1, -1, -1, 30'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL full_result missing idx=%0d", e.idx);
      else begin
        g = got_q.pop_front();
        if (g.idx !== e.idx || g.acc !== e.acc || g.last !== e.last || g.k !== e.k || g.cfg !== e.cfg)
          $display("FAIL full_result got idx=%0d acc=%0d last=%0h k=%0d required idx=%0d acc=%0d last=%0h k=%0d",
                   g.idx, g.acc, g.last, g.k, e.idx, e.acc, e.last, e.k);
        else n_pass++;
      end
    end
    n_checks++;
    if (done_k != 259) $display("FAIL full_done got=%0d required=259", done_k); else n_pass++;
    n_checks++;
    if (pe_cnt != 256) $display("FAIL full_pe_en got=%0d required=256", pe_cnt); else n_pass++;
  endtask

  task automatic test_abort();
    res_t e, g;
    for (int i = 0; i < 3; i++) write_entry(3'(i), 30'h200 + 30'(i), 8'h20 + 8'(i));
    y_outmem = 8'h3C; n_last = 3'd2;
    push_exp(0, 240, 8'h3C, 6, 30'h200, 8'h20);
    start4 = 1'b1;
    // k=9 is the second cycle of entry 1's window.
    observe(16, 1'b0, 9, -1, 30'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL abort_result missing idx=%0d", e.idx);
      else begin
        g = got_q.pop_front();
        if (g.idx !== e.idx || g.acc !== e.acc || g.last !== e.last || g.k !== e.k || g.cfg !== e.cfg)
          $display("FAIL abort_result got idx=%0d acc=%0d k=%0d required idx=%0d acc=%0d k=%0d",
                   g.idx, g.acc, g.k, e.idx, e.acc, e.k);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0) $display("FAIL abort_extra got=%0d required=0", got_q.size()); else n_pass++;
    n_checks++;
    if (done_k != -1) $display("FAIL abort_done got=%0d required=-1", done_k); else n_pass++;
    n_checks++;
    if (last_busy_k != 9) $display("FAIL abort_busy got=%0d required=9", last_busy_k); else n_pass++;
    n_checks++;
    if (pe_cnt != 6) $display("FAIL abort_pe_en got=%0d required=6", pe_cnt); else n_pass++;
    n_checks++;
    if ({cfg4, xm4, ri4, ra4} !== {30'h201, 8'h21, 3'd0, 16'd240})
      $display("FAIL abort_hold got cfg=%h xm=%h idx=%0d acc=%0d required cfg=201 xm=21 idx=0 acc=240",
               cfg4, xm4, ri4, ra4);
    else n_pass++;
  endtask

  task automatic test_write_rules();
    res_t e, g;
    y_outmem = 8'h01; n_last = 3'd0;
    for (int run = 0; run < 2; run++) begin
      if (run == 0) begin
        wr_en = 1'b1; wr_addr = 3'd0; wr_cfg = 30'h1; wr_xmem = 8'h05;
      end
      push_exp(0, 4, 8'h01, 6, 30'h1, 8'h05);
      start4 = 1'b1;
      // The k=3 write lands while busy and must be dropped.
      observe(9, 1'b0, -1, 3, 30'h2);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (got_q.size() == 0) $display("FAIL write_result run=%0d missing", run);
        else begin
          g = got_q.pop_front();
          if (g.cfg !== e.cfg || g.xm !== e.xm || g.acc !== e.acc || g.k !== e.k)
            $display("FAIL write_result run=%0d got cfg=%h xm=%h acc=%0d k=%0d required cfg=%h xm=%h acc=%0d k=%0d",
                     run, g.cfg, g.xm, g.acc, g.k, e.cfg, e.xm, e.acc, e.k);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_cfg = '0; wr_xmem = '0;
    n_last = '0; start4 = 1'b0; start256 = 1'b0; abort = 1'b0; abort256 = 1'b0;
    y_outmem = '0;
    test_reset();
    test_single();
    test_multi();
    test_full_scale();
    test_abort();
    test_write_rules();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_seq_ctrl.md
# pe_seq_ctrl

Sequencer that configures and runs the stochastic-computing PE over a programmed list of operations. A host loads up to DEPTH entries, each a 30-bit `config_sig` word plus an 8-bit `x_mem` operand, then pulses `start`. The block applies each entry to the PE for a fixed bitstream window of RUN_LEN cycles and accumulates the PE's `y_outmem` over that window. It then emits one result per entry. It sits between the host/config memory and a single PE instance; `x1`/`x2` streams are driven by other logic.

## Interface
- DEPTH, 8, number of program entries
- AW, 3, entry address width (DEPTH = 2^AW)
- RUN_LEN, 256, PE cycles per entry (≥1, ≤ 2^CNT_W)
- CNT_W, 8, window counter width
- ACC_W, 16, accumulator width (= 8 + CNT_W)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  program write strobe
- wr_addr  in  AW  entry index
- wr_cfg  in  30  config word for entry
- wr_xmem  in  8  x_mem operand for entry
- n_last  in  AW  index of last entry to execute, sampled on accepted start
- start  in  1  begin sequence (level sampled, accepted only in IDLE)
- abort  in  1  terminate sequence
- y_outmem  in  8  PE memory-side output (combinational from config_sig/x_mem)
- config_sig  out  30  PE configuration
- x_mem  out  8  PE memory operand
- pe_en  out  1  high while PE window is active
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at sequence end
- res_valid  out  1  one-cycle result strobe
- res_idx  out  AW  entry index of result
- res_acc  out  ACC_W  sum of y_outmem over window
- res_last  out  8  y_outmem on final window cycle

## Operation
- Program memory: DEPTH × 38 bits, registered write when wr_en && state==IDLE; writes while busy are dropped. Contents are not cleared by rst.
- FSM states: IDLE, LOAD, RUN, STORE, DONE.
- IDLE: start → LOAD; idx←0, n_last latched. wr_en and start in the same cycle: the write lands, LOAD reads the new data.
- LOAD (1 cycle): config_sig/x_mem ← mem[idx] (visible from next cycle); cnt←0, acc←0 → RUN.
- RUN (RUN_LEN cycles): pe_en=1; acc += y_outmem (zero-extended); cnt++. On cnt==RUN_LEN-1: res_last←y_outmem, acc includes this sample → STORE.
- STORE (1 cycle): res_valid=1, res_idx=idx, res_acc/res_last stable. idx==n_last → DONE, else idx++ → LOAD.
- DONE (1 cycle): done=1 → IDLE.
- Accumulator: 8+CNT_W bits, cannot overflow (max 255·RUN_LEN). Unsigned, no saturation.
- config_sig/x_mem hold last applied values after DONE/abort until next LOAD.
- start while busy: ignored. abort in IDLE: ignored.
- abort in LOAD/RUN/STORE/DONE: next state IDLE; pe_en, res_valid, done forced low in that next cycle; a STORE cycle coincident with abort still emits its res_valid; no done pulse.
- rst mid-operation: same as power-on reset, state→IDLE.

## Timing
- Reset values: config_sig=0, x_mem=0, pe_en=0, busy=0, done=0, res_valid=0, res_idx=0, res_acc=0, res_last=0.
- start sampled at cycle T: LOAD at T+1; entry k RUN spans T+2+k(RUN_LEN+2) … T+1+k(RUN_LEN+2)+RUN_LEN; its STORE at T+(k+1)(RUN_LEN+2).
- done at T+1+N(RUN_LEN+2), N = n_last+1; busy high T+1 through done cycle inclusive.
- res_acc/res_last/res_idx registered; held valid from STORE until next STORE.
- One result per entry, in index order; no back-pressure.

## Test plan
- Reset: assert rst 2 cycles mid-RUN → all outputs 0, state IDLE next cycle.
- Single entry, RUN_LEN=4: mem[0]={30'h0FCFCF1, 8'h3F}, n_last=0, y_outmem=8'h3F, start at T → config_sig=30'h0FCFCF1 and x_mem=8'h3F from T+2, pe_en T+2..T+5, res_valid at T+6 with res_acc=252, res_last=8'h3F, done at T+7.
- Three entries, RUN_LEN=4, y_outmem=8'h3C, n_last=2 → res_valid at T+6, T+12, T+18 with idx 0,1,2, res_acc=240 each, done at T+19, config_sig tracks each entry.
- Full scale, RUN_LEN=256: y_outmem=8'hFF → res_acc=65280, res_last=8'hFF, done at T+259.
- Abort: n_last=2, RUN_LEN=4, abort during entry 1 RUN → IDLE next cycle, only idx 0 result, no done, busy low.
- Write rules: wr_en to addr 0 (cfg 30'h1) coincident with start → entry 0 runs cfg 30'h1; wr_en to addr 0 while busy → ignored, next run still uses 30'h1.
